display_scan_ctrl: RTL
======================

// Module: display_scan_ctrl
// PURPOSE
//   Time-multiplexes N_DIG 7-segment digits onto one shared active-low segment bus.
//   Driven by the system clock plus a 1-cycle scan tick from the display clock divider (64 Hz domain, pre-synchronised).
//   Inserts dead time between digits to stop ghosting.
//   New digit values are accepted via valid/ready and applied only at frame boundaries (tear-free).
// PARAMETERS
//   N_DIG     4   number of digits scanned (2..8)
//   DEAD_CYC  4   clk cycles of all-anodes-off between digits (1..255, must be < tick period)
// PORTS
//   clk        in   1        system clock (50 MHz)
//   rst_n      in   1        asynchronous active-low reset
//   tick       in   1        1-cycle scan-advance pulse, synchronous to clk
//   enable     in   1        1 = scanning, 0 = display dark
//   dig_data   in   4*N_DIG  hex nibble per digit, digit 0 in [3:0]
//   dig_blank  in   N_DIG    1 = digit blanked
//   upd_valid  in   1        update request
//   upd_ready  out  1        pending slot free
//   seg        out  7        gfedcba, active-low
//   an         out  N_DIG    digit anodes, active-low
//   frame_done out  1        1-cycle pulse when last digit's drive ends
//   bright     in   4        duty level (present only with DISPLAY_DIMMING_EN)
// BEHAVIOUR
// - Reset values: seg=7'h7F, an=all 1, frame_done=0, upd_ready=1, idx=0, state=IDLE.
//   Active regs: data=0, blank=all 1. Pending flag=0.
// - FSM (registered outputs, 1-cycle latency from state to pins):
//   IDLE  : an/seg off; tick&enable -> BLANK, dead counter=DEAD_CYC.
//   BLANK : an/seg off; counter decrements each clk; at 1 -> DRIVE.
//   DRIVE : an[idx]=0, seg=decode(active[idx]); held until next tick.
//     On tick with idx<N_DIG-1: idx++ and -> BLANK.
//     On tick with idx==N_DIG-1: idx=0, frame_done=1 for one cycle,
//       pending->active copy if flag set, then -> BLANK.
// - Tick during BLANK or IDLE-without-enable is ignored (no queueing).
// - enable=0 in any state: next cycle IDLE, outputs off, idx=0.
//   Active and pending contents are retained.
// - Decode: 0-F hex to standard active-low pattern (0=7'h40, 8=7'h00, F=7'h0E).
//   Blanked digit drives 7'h7F but still occupies its time slot.
// - Handshake:
//   Transfer = upd_valid & upd_ready; it captures dig_data/dig_blank into pending, sets flag, upd_ready=0 next cycle.
//   Copy at frame boundary clears flag; upd_ready=1 the following cycle.
//   Simultaneous transfer and boundary is impossible (ready=0 when flag=1).
//   Transfer in the cycle after a boundary is applied at the next boundary.
// - Only the digit-index, dead counter and pending flag are stateful besides registers above.
//   idx wraps N_DIG-1 -> 0, never exceeds N_DIG-1.
// - Async reset mid-frame: all outputs to reset values immediately; any pending update is lost.
// CONFIGURATION
// - DISPLAY_DIMMING_EN defined:
//   A 4-bit free-running counter pwm_cnt increments every clk.
//   In DRIVE, an[idx] is asserted only while pwm_cnt < bright; seg is unaffected.
//   bright=0 -> dark; bright=15 -> 15/16 duty. Reset pwm_cnt=0.
// - Not defined: bright port absent, full duty in DRIVE.
// TESTING
// 1. Reset, enable=1, load data=16'h4321 (blank=0), 8 ticks
//    -> an cycles 1110,1101,1011,0111,...; seg 7'h79,7'h24,7'h30,7'h19 for digits 0-3.
// 2. After each tick, count cycles -> exactly DEAD_CYC cycles with an=4'hF before next anode asserts.
// 3. Update to 16'hFFFF mid-frame -> old digits shown until frame_done; new from next digit 0.
//    upd_ready low until 1 cycle after boundary.
// 4. Second upd_valid while flag set -> not accepted.
//    dig_blank=4'b0100 -> digit 2 slot shows seg=7'h7F, an[2]=0.
// 5. enable=0 during digit 2 -> next cycle an=4'hF, seg=7'h7F.
//    Re-enable + tick -> scan restarts at digit 0. Assert rst_n=0 mid-DRIVE -> outputs off same cycle.
// 6. With DISPLAY_DIMMING_EN, bright=4 -> an[idx] low for 4 of every 16 clks in DRIVE.
//    bright=0 -> an stays 4'hF.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Scans N_DIG seven-segment digits onto one shared active-low segment bus.
//   All anodes are held off for DEAD_CYC clocks between digits to prevent ghosting.
//   New digit values arrive over a valid/ready handshake. They are copied into
//   the displayed set only when a frame wraps, so a frame never mixes old and new digits.
//   Optional feature macro: DISPLAY_DIMMING_EN adds i_bright, which PWM-gates the anodes.
module display_scan_ctrl #(
  parameter int N_DIG    = 4,
  parameter int DEAD_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_tick,
  input  logic               i_enable,
  input  logic [4*N_DIG-1:0] i_dig_data,
  input  logic [N_DIG-1:0]   i_dig_blank,
  input  logic               i_upd_valid,
  output logic               o_upd_ready,
  output logic [6:0]         o_seg,
  output logic [N_DIG-1:0]   o_an,
  output logic               o_frame_done
`ifdef DISPLAY_DIMMING_EN
  ,
  input  logic [3:0]         i_bright
`endif
);

  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIG - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t             r_state, w_state_nxt;
  logic [IW-1:0]      r_idx, w_idx_nxt;
  logic [7:0]         r_dead, w_dead_nxt;
  logic [4*N_DIG-1:0] r_act_data, r_pend_data;
  logic [N_DIG-1:0]   r_act_blank, r_pend_blank;
  logic               r_pend_flag;
  logic [6:0]         r_seg;
  logic [N_DIG-1:0]   r_an;
  logic               r_frame_done;

  logic               w_wrap;
  logic               w_xfer;
  logic               w_drive;
  logic               w_pwm_on;
  logic [3:0]         w_nib;
  logic [6:0]         w_seg_nxt;
  logic [N_DIG-1:0]   w_an_nxt;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0: f_decode = 7'h40;
      4'h1: f_decode = 7'h79;
      4'h2: f_decode = 7'h24;
      4'h3: f_decode = 7'h30;
      4'h4: f_decode = 7'h19;
      4'h5: f_decode = 7'h12;
      4'h6: f_decode = 7'h02;
      4'h7: f_decode = 7'h78;
      4'h8: f_decode = 7'h00;
      4'h9: f_decode = 7'h10;
      4'hA: f_decode = 7'h08;
      4'hB: f_decode = 7'h03;
      4'hC: f_decode = 7'h46;
      4'hD: f_decode = 7'h21;
      4'hE: f_decode = 7'h06;
      default: f_decode = 7'h0E;
    endcase
  endfunction

`ifdef DISPLAY_DIMMING_EN
  logic [3:0] r_pwm_cnt;

  // Free-running PWM phase counter for anode dimming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm_cnt <= 4'd0;
    else        r_pwm_cnt <= r_pwm_cnt + 4'd1;
  end

  assign w_pwm_on = (r_pwm_cnt < i_bright);
`else
  assign w_pwm_on = 1'b1;
`endif

  // Next state: enable low forces IDLE; a tick in DRIVE advances or wraps the digit
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_dead_nxt  = r_dead;
    w_wrap      = 1'b0;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_tick) begin
            w_state_nxt = S_BLANK;
            w_dead_nxt  = 8'(DEAD_CYC);
          end
        end
        S_BLANK: begin
          if (r_dead <= 8'd1) w_state_nxt = S_DRIVE;
          else                w_dead_nxt  = r_dead - 8'd1;
        end
        S_DRIVE: begin
          if (i_tick) begin
            w_state_nxt = S_BLANK;
            w_dead_nxt  = 8'(DEAD_CYC);
            if (r_idx == LAST_IDX) begin
              w_idx_nxt = '0;
              w_wrap    = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // Pin values for the next cycle, derived from the current state
  always_comb begin
    w_drive   = i_enable && (r_state == S_DRIVE);
    w_nib     = r_act_data[{r_idx, 2'b00} +: 4];
    w_seg_nxt = 7'h7F;
    w_an_nxt  = '1;
    if (w_drive) begin
      w_seg_nxt = r_act_blank[r_idx] ? 7'h7F : f_decode(w_nib);
      if (w_pwm_on) w_an_nxt[r_idx] = 1'b0;
    end
  end

  assign w_xfer = i_upd_valid && !r_pend_flag;

  // FSM state, digit index and dead-time counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_dead  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_dead  <= w_dead_nxt;
    end
  end

  // Registered display pins and frame boundary pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= 7'h7F;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_nxt;
      r_an         <= w_an_nxt;
      r_frame_done <= w_wrap;
    end
  end

  // Pending slot capture and frame-boundary copy. A capture and a copy never
  // coincide, because the slot only accepts data while the flag is clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_flag  <= 1'b0;
      r_pend_data  <= '0;
      r_pend_blank <= '1;
      r_act_data   <= '0;
      r_act_blank  <= '1;
    end else if (w_xfer) begin
      r_pend_flag  <= 1'b1;
      r_pend_data  <= i_dig_data;
      r_pend_blank <= i_dig_blank;
    end else if (w_wrap && r_pend_flag) begin
      r_pend_flag  <= 1'b0;
      r_act_data   <= r_pend_data;
      r_act_blank  <= r_pend_blank;
    end
  end

  assign o_upd_ready  = ~r_pend_flag;
  assign o_seg        = r_seg;
  assign o_an         = r_an;
  assign o_frame_done = r_frame_done;

endmodule
